patch_extractor: RTL and testbench

// - Fetches one KxK pixel window from the single-port image RAM, starting at a top-left pixel address.
// - Returns the window as one flat word to the convolution datapath.
// - Sits between the controller FSM and image memory:
//   - pixel_addr/load_conv from the controller drive base_addr/req here.
//   - patch_valid here closes the controller's CONVOLVE-state handshake.

---
 rtl/patch_extractor.sv | 193 +++++++++++++++++++
 tb/tb_patch_extractor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/patch_extractor.sv
// Fetches one KxK pixel window from a single-port image RAM and presents it
// as a flat word. Pixel i = kr*K + kc sits at patch_data[i*PIX_W +: PIX_W].
// The first read goes out on the accepting edge, so the strobe and address
// are already registered when the FSM enters FETCH. The RAM returns each
// pixel one cycle after the read is issued, and the pixel is captured on the
// edge that ends the cycle in which its strobe is visible.
module patch_extractor #(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int K      = 3,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [ADDR_W-1:0]      base_addr,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [PIX_W-1:0]       mem_rdata,
  output logic [K*K*PIX_W-1:0]   patch_data,
  output logic                   patch_valid,
  output logic                   patch_err,
  output logic                   busy
);

  localparam int NPIX  = K * K;
  localparam int PW    = NPIX * PIX_W;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  kr, kc;
  logic [CNT_W-1:0]  cur_kr, cur_kc;
  logic [CNT_W-1:0]  adv_kr, adv_kc;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] issue_addr;
  logic [IDX_W-1:0]  issue_idx;
  logic              last_read;
  logic              issue;
  logic              range_err;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  rd_idx;
  logic [PW-1:0]     patch_q;
  logic              err_q;

  // A window is legal only if all K rows and K columns fit inside the image.
  always_comb begin
    int br;
    int bc;
    br = int'(base_addr) / IMG_W;
    bc = int'(base_addr) % IMG_W;
    range_err = (br > IMG_H - K) || (bc > IMG_W - K);
  end

  // Address and slot of the read that would be issued this cycle; in IDLE the
  // window origin comes straight from base_addr since it is not latched yet.
  always_comb begin
    cur_kr     = (state == IDLE) ? '0 : kr;
    cur_kc     = (state == IDLE) ? '0 : kc;
    src_base   = (state == IDLE) ? base_addr : base_q;
    issue_addr = ADDR_W'(int'(src_base) + int'(cur_kr) * IMG_W + int'(cur_kc));
    issue_idx  = IDX_W'(int'(cur_kr) * K + int'(cur_kc));
    last_read  = (int'(cur_kr) == K - 1) && (int'(cur_kc) == K - 1);
    if (int'(cur_kc) == K - 1) begin
      adv_kc = '0;
      adv_kr = cur_kr + CNT_W'(1);
    end else begin
      adv_kc = cur_kc + CNT_W'(1);
      adv_kr = cur_kr;
    end
  end

  // Next-state logic; dropping req in FETCH/DRAIN aborts without a result.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (range_err) begin
            next_state = HOLD;
          end else begin
            issue      = 1'b1;
            next_state = last_read ? DRAIN : FETCH;
          end
        end
      end
      FETCH: begin
        if (!req) begin
          next_state = IDLE;
        end else begin
          issue = 1'b1;
          if (last_read) begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        next_state = req ? HOLD : IDLE;
      end
      HOLD: begin
        if (!req) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Read strobe, address and kernel counters; the address holds when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      rd_idx  <= '0;
      kr      <= '0;
      kc      <= '0;
      base_q  <= '0;
    end else begin
      rd_en_q <= issue;
      if (state == IDLE && req) begin
        base_q <= base_addr;
      end
      if (issue) begin
        addr_q <= issue_addr;
        rd_idx <= issue_idx;
        kr     <= adv_kr;
        kc     <= adv_kc;
      end
      if (next_state == IDLE) begin
        kr <= '0;
        kc <= '0;
      end
    end
  end

  // The registered strobe doubles as the read-pending bit; a pending pixel is
  // dropped if req falls on the edge that would have captured it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      patch_q <= '0;
    end else if (state == IDLE && req) begin
      patch_q <= '0;
    end else if (rd_en_q && req) begin
      for (int i = 0; i < NPIX; i++) begin
        if (rd_idx == IDX_W'(i)) begin
          patch_q[i*PIX_W +: PIX_W] <= mem_rdata;
        end
      end
    end
  end

  // Error flag is decided at acceptance and cleared when the handshake ends.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state == IDLE) begin
      err_q <= req && range_err;
    end else if (next_state == IDLE) begin
      err_q <= 1'b0;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = addr_q;
  assign patch_data  = patch_q;
  assign patch_err   = err_q;
  assign patch_valid = (state == HOLD);
  assign busy        = (state == FETCH) || (state == DRAIN);

endmodule

// File: tb/tb_patch_extractor.sv
// Bench for patch_extractor: directed cases plus random window origins,
// checked against an arithmetic model of the window (RAM[i] = i + 16).
module tb_patch_extractor;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int K      = 3;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 4;
  localparam int NPIX   = K * K;
  localparam int PW     = NPIX * PIX_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic [PW-1:0]     patch_data;
  logic              patch_valid;
  logic              patch_err;
  logic              busy;

  logic [PIX_W-1:0]  ram [IMG_W*IMG_H];

  int vectors = 0;
  int miscompares = 0;

  // 100 MHz clock.
  always #5 clk = ~clk;

  // The RAM's address register is the DUT's registered mem_addr, so data for
  // a read is present in the cycle after the read was issued.
  assign mem_rdata = ram[mem_addr];

  patch_extractor #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .PIX_W(PIX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .base_addr(base_addr),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .patch_data(patch_data),
    .patch_valid(patch_valid),
    .patch_err(patch_err),
    .busy(busy)
  );

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of the window, straight from the image geometry.
  function automatic logic window_err(input int b);
    return (b / IMG_W > IMG_H - K) || (b % IMG_W > IMG_W - K);
  endfunction

  function automatic int window_addr(input int b, input int i);
    return b + (i / K) * IMG_W + (i % K);
  endfunction

  function automatic logic [PW-1:0] window_data(input int b);
    logic [PW-1:0] d;
    d = '0;
    for (int i = 0; i < NPIX; i++) begin
      d[i*PIX_W +: PIX_W] = PIX_W'(window_addr(b, i) + 16);
    end
    return d;
  endfunction

  // Full request: accept, fetch, hold req for 'hold' cycles, then release.
  task automatic applyStimulus(input int b, input int hold);
    int reads[$];
    int valid_edge;
    int busy_cycles;
    logic err;
    logic [PW-1:0] exp_data;
    err         = window_err(b);
    exp_data    = err ? '0 : window_data(b);
    valid_edge  = -1;
    busy_cycles = 0;
    base_addr   = ADDR_W'(b);
    req         = 1'b1;
    for (int e = 0; e < 40 && valid_edge < 0; e++) begin
      step();
      base_addr = ~ADDR_W'(b);
      if (mem_rd_en) reads.push_back(int'(mem_addr));
      if (busy) busy_cycles++;
      if (patch_valid) valid_edge = e;
    end
    if (err) begin
      checkOutput($sformatf("b%0d err read count", b), 128'(reads.size()), 128'(0));
      checkOutput($sformatf("b%0d err latency", b), 128'(valid_edge >= 0 && valid_edge <= 1), 128'(1));
      checkOutput($sformatf("b%0d err busy cycles", b), 128'(busy_cycles), 128'(0));
    end else begin
      checkOutput($sformatf("b%0d read count", b), 128'(reads.size()), 128'(NPIX));
      for (int i = 0; i < NPIX && i < reads.size(); i++) begin
        checkOutput($sformatf("b%0d read %0d addr", b, i), 128'(reads[i]), 128'(window_addr(b, i)));
      end
      checkOutput($sformatf("b%0d valid latency", b), 128'(valid_edge), 128'(NPIX));
      checkOutput($sformatf("b%0d busy cycles", b), 128'(busy_cycles), 128'(NPIX));
    end
    checkOutput($sformatf("b%0d patch_err", b), 128'(patch_err), 128'(err));
    checkOutput($sformatf("b%0d patch_data", b), 128'(patch_data), 128'(exp_data));
    for (int h = 0; h < hold; h++) begin
      step();
      checkOutput($sformatf("b%0d hold %0d flags", b, h),
                  128'({patch_valid, busy, patch_err, mem_rd_en}), 128'({1'b1, 1'b0, err, 1'b0}));
      checkOutput($sformatf("b%0d hold %0d data", b, h), 128'(patch_data), 128'(exp_data));
    end
    req = 1'b0;
    step();
    checkOutput($sformatf("b%0d release flags", b),
                128'({patch_valid, patch_err, busy, mem_rd_en}), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < IMG_W * IMG_H; i++) ram[i] = PIX_W'(i + 16);

    $display("[TB] reset state");
    reset = 1'b0;
    repeat (3) step();
    checkOutput("reset outputs",
                128'({mem_rd_en, mem_addr, patch_data, patch_valid, patch_err, busy}), 128'(0));
    reset = 1'b1;
    step();

    $display("[TB] directed windows");
    applyStimulus(0, 5);
    applyStimulus(5, 5);
    applyStimulus(2, 5);
    applyStimulus(10, 1);
    applyStimulus(8, 1);

    $display("[TB] abort after the 4th read");
    base_addr = ADDR_W'(0);
    req = 1'b1;
    repeat (4) step();
    checkOutput("abort pre-drop read", 128'({mem_rd_en, mem_addr}), 128'({1'b1, ADDR_W'(window_addr(0, 3))}));
    req = 1'b0;
    step();
    checkOutput("abort idle flags", 128'({busy, mem_rd_en, patch_valid}), 128'(0));
    checkOutput("abort addr held", 128'(mem_addr), 128'(window_addr(0, 3)));
    repeat (3) step();
    checkOutput("abort no valid", 128'({busy, mem_rd_en, patch_valid}), 128'(0));
    applyStimulus(1, 2);

    $display("[TB] reset mid-fetch");
    base_addr = ADDR_W'(0);
    req = 1'b1;
    repeat (4) step();
    checkOutput("mid-fetch busy", 128'(busy), 128'(1));
    reset = 1'b0;
    step();
    checkOutput("mid-fetch reset outputs",
                128'({mem_rd_en, mem_addr, patch_data, patch_valid, patch_err, busy}), 128'(0));
    req = 1'b0;
    step();
    reset = 1'b1;
    step();
    applyStimulus(0, 1);

    $display("[TB] random windows");
    repeat (10) begin
      applyStimulus(int'($urandom_range(0, IMG_W * IMG_H - 1)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
